// File: rtl/ppu_vram_ctrl_if.sv
// rtl/ppu_vram_ctrl_if.sv - Renderer fetch, CPU PPUDATA and CHR data signals of the PPU VRAM controller
interface ppu_vram_ctrl_if;
    logic [2:0]  mirror_mode;
    logic        ppu_rden;
    logic [13:0] ppu_addr;
    logic [7:0]  ppu_rdata;
    logic        ppu_rvalid;
    logic        cpu_req;
    logic        cpu_we;
    logic [13:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  ext_rdata;
    logic        cpu_ready;
    logic        cpu_done;
    logic [7:0]  cpu_rdata;

    modport master (
        output mirror_mode, ppu_rden, ppu_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ext_rdata,
        input  ppu_rdata, ppu_rvalid, cpu_ready, cpu_done, cpu_rdata
    );

    modport slave (
        input  mirror_mode, ppu_rden, ppu_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ext_rdata,
        output ppu_rdata, ppu_rvalid, cpu_ready, cpu_done, cpu_rdata
    );
endinterface

// File: rtl/ppu_vram_ctrl.sv
// rtl/ppu_vram_ctrl.sv - PPU nametable/palette VRAM controller with renderer-priority CPU arbitration
// Optional VRAM_FOUR_SCREEN_EN: four nametable banks, mode 100 selects bank by addr[11:10].
module ppu_vram_ctrl #(
    parameter int NT_BANK_AW = 10,
    parameter int PAL_BITS   = 6
) (
    input  logic           clk,
    input  logic           reset_n,
    ppu_vram_ctrl_if.slave bus
);

`ifdef VRAM_FOUR_SCREEN_EN
    localparam int BANK_W = 2;
`else
    localparam int BANK_W = 1;
`endif
    localparam int NT_AW    = NT_BANK_AW + BANK_W;
    localparam int NT_DEPTH = 1 << NT_AW;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PEND,
        ST_SERVICE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [7:0]          nt_mem  [NT_DEPTH];
    logic [PAL_BITS-1:0] pal_mem [32];

    logic        pend_we;
    logic [13:0] pend_addr;
    logic [7:0]  pend_wdata;
    logic [7:0]  rd_buf;
    logic [7:0]  ppu_rdata_q;
    logic        ppu_rvalid_q;
    logic [7:0]  cpu_rdata_q;

    logic        have_req;
    logic        svc;
    logic        req_we;
    logic [13:0] req_addr;
    logic [7:0]  req_wdata;
    logic        req_is_pal;
    logic [NT_AW-1:0] cpu_nt_addr;
    logic [NT_AW-1:0] nt_port_addr;
    logic [7:0]  nt_rdata;
    logic        nt_we;
    logic [4:0]  pal_port_idx;
    logic [7:0]  pal_rdata;
    logic        pal_we;
    logic        cpu_ready_c;
    logic        cpu_done_c;

    function automatic logic [NT_AW-1:0] nt_index(input logic [13:0] a, input logic [2:0] mode);
        logic [BANK_W-1:0] bank;
        case (mode)
            3'b000:  bank = BANK_W'(a[11]);
            3'b010:  bank = '0;
            3'b011:  bank = BANK_W'(1);
`ifdef VRAM_FOUR_SCREEN_EN
            3'b100:  bank = a[11:10];
`endif
            default: bank = BANK_W'(a[10]);
        endcase
        return {bank, a[NT_BANK_AW-1:0]};
    endfunction

    function automatic logic is_pal(input logic [13:0] a);
        return a[13:8] == 6'h3F;
    endfunction

    // Backdrop entries $10/$14/$18/$1C share storage with $00/$04/$08/$0C.
    function automatic logic [4:0] pal_index(input logic [13:0] a);
        return (a[4] && (a[1:0] == 2'b00)) ? {1'b0, a[3:0]} : a[4:0];
    endfunction

    // A pending slot takes precedence over the live inputs, which are ignored while cpu_ready is low.
    always_comb begin
        have_req   = (state == ST_PEND) || bus.cpu_req;
        req_we     = (state == ST_PEND) ? pend_we    : bus.cpu_we;
        req_addr   = (state == ST_PEND) ? pend_addr  : bus.cpu_addr;
        req_wdata  = (state == ST_PEND) ? pend_wdata : bus.cpu_wdata;
        svc        = have_req && !bus.ppu_rden;
        req_is_pal = is_pal(req_addr);
    end

    always_comb begin
        cpu_nt_addr  = req_is_pal ? nt_index({6'h2F, req_addr[7:0]}, bus.mirror_mode)
                                  : nt_index(req_addr, bus.mirror_mode);
        nt_port_addr = bus.ppu_rden ? nt_index(bus.ppu_addr, bus.mirror_mode) : cpu_nt_addr;
        nt_rdata     = nt_mem[nt_port_addr];
        nt_we        = svc && req_we && req_addr[13] && !req_is_pal;
        pal_port_idx = bus.ppu_rden ? pal_index(bus.ppu_addr) : pal_index(req_addr);
        pal_we       = svc && req_we && req_is_pal;
        pal_rdata    = '0;
        pal_rdata[PAL_BITS-1:0] = pal_mem[pal_port_idx];
    end

    always_comb begin
        state_nxt   = ST_IDLE;
        cpu_ready_c = 1'b1;
        cpu_done_c  = 1'b0;
        case (state)
            ST_PEND:    cpu_ready_c = 1'b0;
            ST_SERVICE: cpu_done_c  = 1'b1;
            default:    ;
        endcase
        if (svc) begin
            state_nxt = ST_SERVICE;
        end else if (have_req) begin
            state_nxt = ST_PEND;
        end
    end

    always_ff @(posedge clk) begin
        if (nt_we) begin
            nt_mem[nt_port_addr] <= req_wdata;
        end
        if (pal_we) begin
            pal_mem[pal_port_idx] <= req_wdata[PAL_BITS-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            pend_we      <= 1'b0;
            pend_addr    <= '0;
            pend_wdata   <= '0;
            rd_buf       <= 8'h00;
            ppu_rdata_q  <= 8'h00;
            ppu_rvalid_q <= 1'b0;
            cpu_rdata_q  <= 8'h00;
        end else begin
            state        <= state_nxt;
            ppu_rvalid_q <= bus.ppu_rden;
            if (bus.ppu_rden) begin
                if (!bus.ppu_addr[13]) begin
                    ppu_rdata_q <= 8'h00;
                end else if (is_pal(bus.ppu_addr)) begin
                    ppu_rdata_q <= pal_rdata;
                end else begin
                    ppu_rdata_q <= nt_rdata;
                end
            end
            if ((state != ST_PEND) && bus.cpu_req) begin
                pend_we    <= bus.cpu_we;
                pend_addr  <= bus.cpu_addr;
                pend_wdata <= bus.cpu_wdata;
            end
            // Palette reads bypass the buffer but still refill it from the nametable underneath.
            if (svc && !req_we) begin
                if (!req_addr[13]) begin
                    cpu_rdata_q <= rd_buf;
                    rd_buf      <= bus.ext_rdata;
                end else if (req_is_pal) begin
                    cpu_rdata_q <= pal_rdata;
                    rd_buf      <= nt_rdata;
                end else begin
                    cpu_rdata_q <= rd_buf;
                    rd_buf      <= nt_rdata;
                end
            end
        end
    end

    assign bus.ppu_rdata  = ppu_rdata_q;
    assign bus.ppu_rvalid = ppu_rvalid_q;
    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.cpu_ready  = cpu_ready_c;
    assign bus.cpu_done   = cpu_done_c;

endmodule

// File: tb/tb_ppu_vram_ctrl.sv
// tb/tb_ppu_vram_ctrl.sv - Self-checking bench for ppu_vram_ctrl with a behavioural VRAM model
module tb_ppu_vram_ctrl;
    localparam int NT_BANK_AW = 10;
    localparam int PAL_BITS   = 6;
`ifdef VRAM_FOUR_SCREEN_EN
    localparam bit FOUR = 1'b1;
`else
    localparam bit FOUR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    logic [7:0] m_nt  [4096];
    logic [7:0] m_pal [32];
    logic [7:0] m_buf;

    ppu_vram_ctrl_if bus ();

    ppu_vram_ctrl #(.NT_BANK_AW(NT_BANK_AW), .PAL_BITS(PAL_BITS)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic int mdl_nt_idx(input logic [13:0] a, input logic [2:0] m);
        int bank;
        int a10 = int'(a[10]);
        int a11 = int'(a[11]);
        case (m)
            3'd0:    bank = a11;
            3'd1:    bank = a10;
            3'd2:    bank = 0;
            3'd3:    bank = 1;
            3'd4:    bank = FOUR ? 2 * a11 + a10 : a10;
            default: bank = a10;
        endcase
        return bank * 1024 + int'(a) % 1024;
    endfunction

    function automatic bit mdl_is_pal(input logic [13:0] a);
        return a[13:8] == 6'h3F;
    endfunction

    function automatic int mdl_pal_idx(input logic [13:0] a);
        int i = int'(a) % 32;
        if (i >= 16 && i % 4 == 0) i -= 16;
        return i;
    endfunction

    function automatic logic [7:0] mdl_ppu_read(input logic [13:0] a, input logic [2:0] m);
        if (int'(a) < 'h2000) return 8'h00;
        if (mdl_is_pal(a)) return m_pal[mdl_pal_idx(a)];
        return m_nt[mdl_nt_idx(a, m)];
    endfunction

    task automatic mdl_cpu(input logic we, input logic [13:0] a, input logic [7:0] d,
                           input logic [7:0] ext, input logic [2:0] m, output logic [7:0] rd);
        rd = 8'h00;
        if (we) begin
            if (int'(a) >= 'h2000) begin
                if (mdl_is_pal(a)) m_pal[mdl_pal_idx(a)] = d & 8'((1 << PAL_BITS) - 1);
                else m_nt[mdl_nt_idx(a, m)] = d;
            end
        end else if (int'(a) < 'h2000) begin
            rd = m_buf;
            m_buf = ext;
        end else if (mdl_is_pal(a)) begin
            rd = m_pal[mdl_pal_idx(a)];
            m_buf = m_nt[mdl_nt_idx(14'h2F00 | (a & 14'h00FF), m)];
        end else begin
            rd = m_buf;
            m_buf = m_nt[mdl_nt_idx(a, m)];
        end
    endtask

    task automatic cpu_op(input logic we, input logic [13:0] a, input logic [7:0] d,
                          input logic [7:0] ext, output logic [7:0] rd, output logic [7:0] exp_rd);
        int n;
        @(posedge clk); #1;
        bus.ppu_rden  = 1'b0;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
        bus.ext_rdata = ext;
        mdl_cpu(we, a, d, ext, bus.mirror_mode, exp_rd);
        @(posedge clk); #1;
        bus.cpu_req = 1'b0;
        n = 0;
        while (bus.cpu_done !== 1'b1 && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 8) begin
            checks++; errors++;
            $display("FAIL cpu_done_timeout: cpu_done=%b required=1 addr=%h", bus.cpu_done, a);
        end
        rd = bus.cpu_rdata;
    endtask

    task automatic ppu_fetch(input logic [13:0] a, output logic [7:0] rd, output logic v);
        @(posedge clk); #1;
        bus.ppu_rden = 1'b1;
        bus.ppu_addr = a;
        bus.cpu_req  = 1'b0;
        @(posedge clk); #1;
        bus.ppu_rden = 1'b0;
        rd = bus.ppu_rdata;
        v  = bus.ppu_rvalid;
    endtask

    task automatic test_reset;
        bus.mirror_mode = 3'd1;
        bus.ppu_rden    = 1'b0;
        bus.ppu_addr    = '0;
        bus.cpu_req     = 1'b0;
        bus.cpu_we      = 1'b0;
        bus.cpu_addr    = '0;
        bus.cpu_wdata   = '0;
        bus.ext_rdata   = '0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.ppu_rvalid !== 1'b0) begin errors++; $display("FAIL reset_ppu_rvalid: got=%b required=0", bus.ppu_rvalid); end
        checks++; if (bus.cpu_done !== 1'b0) begin errors++; $display("FAIL reset_cpu_done: got=%b required=0", bus.cpu_done); end
        checks++; if (bus.cpu_ready !== 1'b1) begin errors++; $display("FAIL reset_cpu_ready: got=%b required=1", bus.cpu_ready); end
        checks++; if (bus.cpu_rdata !== 8'h00) begin errors++; $display("FAIL reset_cpu_rdata: got=%h required=00", bus.cpu_rdata); end
        checks++; if (bus.ppu_rdata !== 8'h00) begin errors++; $display("FAIL reset_ppu_rdata: got=%h required=00", bus.ppu_rdata); end
        @(negedge clk);
        reset_n = 1'b1;
        m_buf = 8'h00;
    endtask

    task automatic init_mem;
        logic [7:0] rd, er;
        int span;
        bus.mirror_mode = FOUR ? 3'd4 : 3'd1;
        span = FOUR ? 4096 : 2048;
        for (int i = 0; i < span; i++) cpu_op(1'b1, 14'(14'h2000 + i), 8'h00, 8'h00, rd, er);
        for (int i = 0; i < 32; i++) cpu_op(1'b1, 14'(14'h3F00 + i), 8'h00, 8'h00, rd, er);
    endtask

    task automatic test_mirroring;
        logic [7:0] rd, er;
        logic v;
        bus.mirror_mode = 3'd0;
        cpu_op(1'b1, 14'h2005, 8'hA5, 8'h00, rd, er);
        ppu_fetch(14'h2405, rd, v);
        checks++; if (v !== 1'b1 || rd !== 8'hA5) begin errors++; $display("FAIL horiz_2405: got=%h v=%b required=a5", rd, v); end
        ppu_fetch(14'h2805, rd, v);
        checks++; if (v !== 1'b1 || rd !== 8'h00) begin errors++; $display("FAIL horiz_2805: got=%h v=%b required=00", rd, v); end
        bus.mirror_mode = 3'd1;
        cpu_op(1'b1, 14'h2005, 8'h3C, 8'h00, rd, er);
        ppu_fetch(14'h2805, rd, v);
        checks++; if (v !== 1'b1 || rd !== 8'h3C) begin errors++; $display("FAIL vert_2805: got=%h v=%b required=3c", rd, v); end
        ppu_fetch(14'h2405, rd, v);
        checks++; if (v !== 1'b1 || rd !== 8'h00) begin errors++; $display("FAIL vert_2405: got=%h v=%b required=00", rd, v); end
        ppu_fetch(14'h3005, rd, v);
        checks++; if (v !== 1'b1 || rd !== 8'h3C) begin errors++; $display("FAIL mirror_3005: got=%h v=%b required=3c", rd, v); end
        ppu_fetch(14'h0005, rd, v);
        checks++; if (v !== 1'b1 || rd !== 8'h00) begin errors++; $display("FAIL chr_fetch_zero: got=%h v=%b required=00", rd, v); end
    endtask

    task automatic test_buffered_read;
        logic [7:0] rd, er;
        bus.mirror_mode = 3'd1;
        cpu_op(1'b1, 14'h2000, 8'h11, 8'h00, rd, er);
        cpu_op(1'b1, 14'h2001, 8'h22, 8'h00, rd, er);
        cpu_op(1'b0, 14'h2000, 8'h00, 8'h00, rd, er);
        checks++; if (rd !== er) begin errors++; $display("FAIL buf_first: got=%h required=%h", rd, er); end
        cpu_op(1'b0, 14'h2001, 8'h00, 8'h00, rd, er);
        checks++; if (rd !== 8'h11) begin errors++; $display("FAIL buf_second: got=%h required=11", rd); end
        cpu_op(1'b1, 14'h2F00, 8'h77, 8'h00, rd, er);
        cpu_op(1'b1, 14'h3F00, 8'h2C, 8'h00, rd, er);
        cpu_op(1'b0, 14'h3F00, 8'h00, 8'h00, rd, er);
        checks++; if (rd !== 8'h2C) begin errors++; $display("FAIL pal_direct: got=%h required=2c", rd); end
        cpu_op(1'b0, 14'h2001, 8'h00, 8'h00, rd, er);
        checks++; if (rd !== 8'h77) begin errors++; $display("FAIL pal_buf_2f00: got=%h required=77", rd); end
        cpu_op(1'b0, 14'h0123, 8'h00, 8'h9E, rd, er);
        checks++; if (rd !== 8'h22) begin errors++; $display("FAIL chr_buf_prev: got=%h required=22", rd); end
        cpu_op(1'b0, 14'h0124, 8'h00, 8'h00, rd, er);
        checks++; if (rd !== 8'h9E) begin errors++; $display("FAIL chr_buf_ext: got=%h required=9e", rd); end
    endtask

    task automatic test_palette_alias;
        logic [7:0] rd, er;
        logic v;
        cpu_op(1'b1, 14'h3F11, 8'h2A, 8'h00, rd, er);
        cpu_op(1'b1, 14'h3F00, 8'h05, 8'h00, rd, er);
        cpu_op(1'b1, 14'h3F10, 8'hFF, 8'h00, rd, er);
        cpu_op(1'b0, 14'h3F00, 8'h00, 8'h00, rd, er);
        checks++; if (rd !== 8'h3F) begin errors++; $display("FAIL pal_alias_3f00: got=%h required=3f", rd); end
        cpu_op(1'b0, 14'h3F11, 8'h00, 8'h00, rd, er);
        checks++; if (rd !== 8'h2A) begin errors++; $display("FAIL pal_3f11: got=%h required=2a", rd); end
        cpu_op(1'b0, 14'h3F30, 8'h00, 8'h00, rd, er);
        checks++; if (rd !== 8'h3F) begin errors++; $display("FAIL pal_mirror_3f30: got=%h required=3f", rd); end
        ppu_fetch(14'h3F10, rd, v);
        checks++; if (v !== 1'b1 || rd !== 8'h3F) begin errors++; $display("FAIL pal_fetch_3f10: got=%h v=%b required=3f", rd, v); end
    endtask

    task automatic test_conflict;
        logic [7:0] old_v, old_n, rd, er;
        logic v;
        bus.mirror_mode = 3'd1;
        old_v = m_nt[mdl_nt_idx(14'h2123, 3'd1)];
        old_n = m_nt[mdl_nt_idx(14'h2124, 3'd1)];
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (c >= 2 && c <= 6) begin
                checks++; if (bus.cpu_ready !== 1'b0) begin errors++; $display("FAIL conflict_ready c%0d: got=%b required=0", c, bus.cpu_ready); end
                checks++; if (bus.cpu_done !== 1'b0) begin errors++; $display("FAIL conflict_early_done c%0d: got=%b required=0", c, bus.cpu_done); end
                checks++; if (bus.ppu_rvalid !== 1'b1 || bus.ppu_rdata !== old_v) begin
                    errors++; $display("FAIL conflict_fetch c%0d: got=%h v=%b required=%h", c, bus.ppu_rdata, bus.ppu_rvalid, old_v);
                end
            end
            if (c == 7) begin
                checks++; if (bus.cpu_done !== 1'b1 || bus.cpu_ready !== 1'b1) begin
                    errors++; $display("FAIL conflict_done: done=%b ready=%b required=1/1", bus.cpu_done, bus.cpu_ready);
                end
            end
            if (c == 8) begin
                checks++; if (bus.cpu_done !== 1'b0) begin errors++; $display("FAIL conflict_done_pulse: got=%b required=0", bus.cpu_done); end
            end
            bus.ppu_rden  = (c <= 5);
            bus.ppu_addr  = 14'h2123;
            bus.cpu_req   = (c == 1 || c == 3);
            bus.cpu_we    = 1'b1;
            bus.cpu_addr  = (c == 1) ? 14'h2123 : 14'h2124;
            bus.cpu_wdata = (c == 1) ? ~old_v : 8'hEE;
        end
        bus.cpu_req = 1'b0;
        mdl_cpu(1'b1, 14'h2123, ~old_v, 8'h00, 3'd1, er);
        ppu_fetch(14'h2123, rd, v);
        checks++; if (rd !== ~old_v) begin errors++; $display("FAIL conflict_written: got=%h required=%h", rd, ~old_v); end
        ppu_fetch(14'h2124, rd, v);
        checks++; if (rd !== old_n) begin errors++; $display("FAIL conflict_ignored_req: got=%h required=%h", rd, old_n); end
    endtask

    task automatic test_reset_pending;
        logic [7:0] old_v, rd, er;
        logic v;
        bus.mirror_mode = 3'd1;
        old_v = m_nt[mdl_nt_idx(14'h2200, 3'd1)];
        @(posedge clk); #1;
        bus.ppu_rden  = 1'b1;
        bus.ppu_addr  = 14'h2000;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 14'h2200;
        bus.cpu_wdata = ~old_v;
        @(posedge clk); #1;
        bus.cpu_req = 1'b0;
        checks++; if (bus.cpu_ready !== 1'b0) begin errors++; $display("FAIL rstp_pending: ready=%b required=0", bus.cpu_ready); end
        reset_n = 1'b0;
        #2;
        checks++; if (bus.cpu_ready !== 1'b1 || bus.cpu_done !== 1'b0 || bus.ppu_rvalid !== 1'b0) begin
            errors++; $display("FAIL rstp_async: ready=%b done=%b rvalid=%b required=1/0/0", bus.cpu_ready, bus.cpu_done, bus.ppu_rvalid);
        end
        bus.ppu_rden = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        m_buf = 8'h00;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++; if (bus.cpu_done !== 1'b0 || bus.cpu_ready !== 1'b1) begin
                errors++; $display("FAIL rstp_no_done %0d: done=%b ready=%b required=0/1", i, bus.cpu_done, bus.cpu_ready);
            end
        end
        ppu_fetch(14'h2200, rd, v);
        checks++; if (rd !== old_v) begin errors++; $display("FAIL rstp_discarded: got=%h required=%h", rd, old_v); end
        cpu_op(1'b0, 14'h2000, 8'h00, 8'h00, rd, er);
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL rstp_buf_cleared: got=%h required=00", rd); end
`ifdef VRAM_FOUR_SCREEN_EN
        bus.mirror_mode = 3'd4;
        for (int b = 0; b < 4; b++) cpu_op(1'b1, 14'(14'h2000 + b * 'h400), 8'(8'hC0 + b), 8'h00, rd, er);
        for (int b = 0; b < 4; b++) begin
            ppu_fetch(14'(14'h2000 + b * 'h400), rd, v);
            checks++; if (rd !== 8'(8'hC0 + b)) begin errors++; $display("FAIL four_screen %0d: got=%h required=%h", b, rd, 8'(8'hC0 + b)); end
        end
`endif
    endtask

    function automatic logic [13:0] rand_addr();
        case ($urandom_range(0, 3))
            0:       return 14'($urandom_range(0, 'h1FFF));
            3:       return 14'('h3F00 + $urandom_range(0, 'hFF));
            default: return 14'('h2000 + $urandom_range(0, 'h1EFF));
        endcase
    endfunction

    task automatic test_random;
        logic [2:0]  modes [6];
        bit          pend;
        logic        p_we, exp_v, exp_done, exp_rd_chk, rden, req, we;
        logic [13:0] p_addr, paddr, caddr;
        logic [7:0]  p_d, d, ext, exp_pd, exp_cd;
        int          n_cyc;
        modes = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'($urandom_range(5, 7))};
        n_cyc = 300;
        for (int ph = 0; ph < 6; ph++) begin
            bus.mirror_mode = modes[ph];
            pend = 0; exp_v = 0; exp_done = 0; exp_rd_chk = 0;
            p_we = 0; p_addr = '0; p_d = '0; exp_pd = '0; exp_cd = '0;
            for (int i = 0; i < n_cyc + 3; i++) begin
                @(posedge clk); #1;
                if (i > 0) begin
                    checks++; if (bus.ppu_rvalid !== exp_v || (exp_v && bus.ppu_rdata !== exp_pd)) begin
                        errors++; $display("FAIL rand_ppu m%0d i%0d: v=%b d=%h required v=%b d=%h", modes[ph], i, bus.ppu_rvalid, bus.ppu_rdata, exp_v, exp_pd);
                    end
                    checks++; if (bus.cpu_done !== exp_done) begin
                        errors++; $display("FAIL rand_done m%0d i%0d: got=%b required=%b", modes[ph], i, bus.cpu_done, exp_done);
                    end
                    checks++; if (bus.cpu_ready !== !pend) begin
                        errors++; $display("FAIL rand_ready m%0d i%0d: got=%b required=%b", modes[ph], i, bus.cpu_ready, !pend);
                    end
                    if (exp_done && exp_rd_chk) begin
                        checks++; if (bus.cpu_rdata !== exp_cd) begin
                            errors++; $display("FAIL rand_cpu_rdata m%0d i%0d: got=%h required=%h", modes[ph], i, bus.cpu_rdata, exp_cd);
                        end
                    end
                end
                rden  = (i < n_cyc) && ($urandom_range(0, 99) < 55);
                req   = (i < n_cyc) && ($urandom_range(0, 1) == 1);
                we    = $urandom_range(0, 1) == 1;
                paddr = rand_addr();
                caddr = rand_addr();
                d     = 8'($urandom);
                ext   = 8'($urandom);
                bus.ppu_rden  = rden;
                bus.ppu_addr  = paddr;
                bus.cpu_req   = req;
                bus.cpu_we    = we;
                bus.cpu_addr  = caddr;
                bus.cpu_wdata = d;
                bus.ext_rdata = ext;
                exp_v = rden;
                if (rden) exp_pd = mdl_ppu_read(paddr, modes[ph]);
                if (!pend && req) begin
                    pend = 1; p_we = we; p_addr = caddr; p_d = d;
                end
                exp_done = 0; exp_rd_chk = 0;
                if (pend && !rden) begin
                    mdl_cpu(p_we, p_addr, p_d, ext, modes[ph], exp_cd);
                    exp_done = 1; exp_rd_chk = !p_we; pend = 0;
                end
            end
        end
        bus.cpu_req  = 1'b0;
        bus.ppu_rden = 1'b0;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        init_mem();
        test_mirroring();
        test_buffered_read();
        test_palette_alias();
        test_conflict();
        test_reset_pending();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
